// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential signed binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_ADD_THRESH = 4'd5;
  localparam bcd_digit_t BCD_NINE = 4'h9;
endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: one BCD digit corrector, adds 3 when the digit is 5 or more
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = (d >= BCD_ADD_THRESH) ? d + 4'd3 : d;
endmodule

// File: rtl/signed_bcd_converter_seq.sv
// signed_bcd_converter_seq: shift-and-add-3 binary to sign-magnitude BCD, one bit per cycle, valid/ready on both sides
// Define BCD_SATURATE_EN to force all-nines on overflow instead of the truncated modulo result.
module signed_bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 18,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  ovf_out
);
  localparam int CW = $clog2(BIN_W + 1);
  state_t state, state_n;
  logic [BIN_W-1:0]    mag;
  logic [4*DIGITS-1:0] acc, corr, acc_n;
  logic [CW-1:0]       cnt;
  logic                sign, ovf, ovf_n, last, sign_c;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_add3_digit u_d (.d(acc[4*i +: 4]), .q(corr[4*i +: 4]));
  end
  always_comb begin
    last    = cnt == CW'(BIN_W - 1);
    sign_c  = (SIGNED != 0) & bin_in[BIN_W-1];
    acc_n   = {corr[4*DIGITS-2:0], mag[BIN_W-1]};
    ovf_n   = ovf | corr[4*DIGITS-1];
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      ovf      <= 1'b0;
      bcd_out  <= '0;
      sign_out <= 1'b0;
      ovf_out  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        sign <= sign_c;
        mag  <= sign_c ? -bin_in : bin_in;
        acc  <= '0;
        ovf  <= 1'b0;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        acc <= acc_n;
        mag <= mag << 1;
        ovf <= ovf_n;
        cnt <= cnt + 1'b1;
        // Results land on the same edge as the final shift, i.e. on DONE entry.
        if (last) begin
`ifdef BCD_SATURATE_EN
          bcd_out <= ovf_n ? {DIGITS{BCD_NINE}} : acc_n;
`else
          bcd_out <= acc_n;
`endif
          sign_out <= sign;
          ovf_out  <= ovf_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_signed_bcd_converter_seq.sv
// tb_signed_bcd_converter_seq: directed self-checking bench for signed_bcd_converter_seq (18-bit, 5 digits, signed)
module tb_signed_bcd_converter_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] bin_in = '0;
  logic        in_ready, out_valid, sign_out, ovf_out;
  logic [19:0] bcd_out;
  int total = 0;
  int bad = 0;

  signed_bcd_converter_seq #(.BIN_W(18), .DIGITS(5), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
    .sign_out(sign_out), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

`ifdef BCD_SATURATE_EN
  localparam logic [19:0] OVF_POS = 20'h99999;
  localparam logic [19:0] OVF_NEG = 20'h99999;
`else
  localparam logic [19:0] OVF_POS = 20'h31071;
  localparam logic [19:0] OVF_NEG = 20'h31072;
`endif

  task automatic start(input logic [17:0] v);
    in_valid = 1'b1;
    bin_in = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, bcd_out, sign_out, ovf_out} !== {1'b1, 1'b0, 20'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b bcd=%h s=%b o=%b, want rdy=1 vld=0 bcd=00000 s=0 o=0",
               in_ready, out_valid, bcd_out, sign_out, ovf_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [17:0] vin  [4] = '{18'd12345, 18'h3D8F1, 18'd131071, 18'h20000};
    logic [19:0] vbcd [4] = '{20'h12345, 20'h09999, OVF_POS, OVF_NEG};
    logic        vs   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        vo   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_idle_ready: got %b want 1", k, in_ready);
      end
      start(vin[k]);
      wait_done(n);
      total++;
      if (n !== 18) begin
        bad++;
        $display("FAIL vec%0d_latency: got %0d cycles want 18", k, n);
      end
      total++;
      if ({bcd_out, sign_out, ovf_out} !== {vbcd[k], vs[k], vo[k]}) begin
        bad++;
        $display("FAIL vec%0d_result: got bcd=%h s=%b o=%b want bcd=%h s=%b o=%b",
                 k, bcd_out, sign_out, ovf_out, vbcd[k], vs[k], vo[k]);
      end
      release_out();
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL vec%0d_return_idle: got vld=%b rdy=%b want vld=0 rdy=1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start(18'd12345);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, bcd_out, sign_out, ovf_out} !== {1'b1, 1'b0, 20'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got rdy=%b vld=%b bcd=%h s=%b o=%b want rdy=1 vld=0 bcd=00000 s=0 o=0",
               in_ready, out_valid, bcd_out, sign_out, ovf_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL mid_reset_no_result: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    start(18'd99999);
    wait_done(n);
    total++;
    if ({n == 18, bcd_out, sign_out, ovf_out} !== {1'b1, 20'h99999, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL after_reset_99999: got n=%0d bcd=%h s=%b o=%b want n=18 bcd=99999 s=0 o=0",
               n, bcd_out, sign_out, ovf_out);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int n;
    start(18'd54321);
    wait_done(n);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      bin_in = 18'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({out_valid, in_ready, bcd_out, sign_out, ovf_out} !== {1'b1, 1'b0, 20'h54321, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b bcd=%h s=%b o=%b want vld=1 rdy=0 bcd=54321 s=0 o=0",
                 k, out_valid, in_ready, bcd_out, sign_out, ovf_out);
      end
    end
    release_out();
    total++;
    if ({out_valid, in_ready, bcd_out} !== {1'b0, 1'b1, 20'h54321}) begin
      bad++;
      $display("FAIL hold_release: got vld=%b rdy=%b bcd=%h want vld=0 rdy=1 bcd=54321", out_valid, in_ready, bcd_out);
    end
    start(18'd0);
    wait_done(n);
    total++;
    if ({n == 18, bcd_out, sign_out, ovf_out} !== {1'b1, 20'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL zero_input: got n=%0d bcd=%h s=%b o=%b want n=18 bcd=00000 s=0 o=0",
               n, bcd_out, sign_out, ovf_out);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_mid();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
